// File: rtl/rnsrisc_pkg.sv
// Shared definitions for the program loader: FSM state encoding and stream framing constants.
package rnsrisc_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHK     = 4'd6,
        DONE    = 4'd7,
        ERR     = 4'd8
    } state_t;

    localparam int LEN_BYTES = 2;
    localparam int CHK_BYTES = 1;

    // States from which a new load may be started.
    function automatic logic accepts_load(input state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/byte_xor_acc.sv
// 8-bit XOR accumulator with synchronous clear (priority) and enable.
module byte_xor_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 8'd0;
        end else if (clr) begin
            acc <= 8'd0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses length/words/checksum, writes instruction memory
// and holds the CPU core in reset until a load completes with a good checksum.
module prog_loader
    import rnsrisc_pkg::*;
#(
    parameter int PROG_CTR_WID = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_req,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    output logic                    mem_we,
    output logic [PROG_CTR_WID-1:0] mem_addr,
    output logic [15:0]             mem_wdata,
    output logic                    cpu_rst_n,
    output logic                    load_done,
    output logic                    load_err
);

    localparam int LEN_W = 8 * LEN_BYTES;
    localparam int CHK_W = 8 * CHK_BYTES;
    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(1) << PROG_CTR_WID;

    state_t               state;
    state_t               state_next;
    logic                 xfer;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     len_rx;
    logic [7:0]           hi_q;
    logic [7:0]           lo_q;
    // One extra bit so the index never wraps, even after the 2^PROG_CTR_WID-th word.
    logic [PROG_CTR_WID:0] idx_q;
    logic                 last_word;
    logic                 acc_clr;
    logic                 acc_en;
    logic [CHK_W-1:0]     chk_acc;

    assign xfer      = byte_valid & byte_ready;
    assign len_rx    = {len_q[LEN_W-1:8], byte_in};
    assign last_word = ((LEN_W + 1)'(idx_q) + (LEN_W + 1)'(1)) == {1'b0, len_q};
    assign mem_addr  = idx_q[PROG_CTR_WID-1:0];
    assign mem_wdata = {hi_q, lo_q};

    byte_xor_acc u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .din   (byte_in),
        .acc   (chk_acc)
    );

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (load_req) begin
                    state_next = LEN_HI;
                    acc_clr    = 1'b1;
                end
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    acc_en     = 1'b1;
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    acc_en = 1'b1;
                    if ({1'b0, len_rx} > MAX_WORDS) begin
                        state_next = ERR;
                    end else if (len_rx == '0) begin
                        state_next = CHK;
                    end else begin
                        state_next = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    acc_en     = 1'b1;
                    state_next = DATA_LO;
                end
            end
            DATA_LO: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    acc_en     = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                state_next = last_word ? CHK : DATA_HI;
            end
            CHK: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    state_next = (byte_in == chk_acc) ? DONE : ERR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status levels are registered from the next state so they line up with the state
    // register and cpu_rst_n stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cpu_rst_n <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_next;
            cpu_rst_n <= (state_next == IDLE) || (state_next == DONE);
            load_done <= (state_next == DONE);
            load_err  <= (state_next == ERR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            hi_q  <= 8'd0;
            lo_q  <= 8'd0;
            idx_q <= '0;
        end else begin
            if (accepts_load(state) && load_req) begin
                idx_q <= '0;
            end
            if (xfer) begin
                case (state)
                    LEN_HI:  len_q[LEN_W-1:8] <= byte_in;
                    LEN_LO:  len_q[7:0]       <= byte_in;
                    DATA_HI: hi_q             <= byte_in;
                    DATA_LO: lo_q             <= byte_in;
                    default: ;
                endcase
            end
            if (state == WRITE) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule
